// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the decode-to-register-read instruction queue:
// the decoded record layout, its field accessors and the default depth.

`ifndef FETCH_QUEUE_PKG_MACROS
`define FETCH_QUEUE_PKG_MACROS
// Field accessors for a flat W-bit record (bit positions match fq_rec_t).
`define FQ_VALID(rec) rec[63]
`define FQ_PATH(rec)  rec[62:60]
`define FQ_PC(rec)    rec[59:12]
`endif

package fetch_queue_pkg;

   // Default number of queue entries (power of two, at least 4).
   localparam int FQ_DEPTH = 8;

   // One decoded instruction record as produced by a decode slot.
   typedef struct packed {
      logic        valid;  // record carries a real instruction
      logic [2:0]  path;   // execution path / issue class
      logic [47:0] pc;     // instruction address
      logic [11:0] ctl;    // decoded control bits
   } fq_rec_t;

   // Record width follows directly from the layout above.
   localparam int FQ_W = $bits(fq_rec_t);

endpackage

// File: rtl/fetch_queue.sv
// Two-in / one-out instruction queue with empty-queue bypass, head hold on
// stall, sticky overflow detection and flush with optional single refill.

module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = FQ_DEPTH,
   parameter int W     = FQ_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enq_a_valid,
   input  logic [W-1:0]               enq_a_data,
   input  logic                       enq_b_valid,
   input  logic [W-1:0]               enq_b_data,
   input  logic                       deq_ready,
   output logic                       deq_valid,
   output logic [W-1:0]               deq_data,
   input  logic                       flush,
   input  logic                       refill_valid,
   input  logic [W-1:0]               refill_data,
   output logic [$clog2(DEPTH):0]     free,
   output logic                       empty,
   output logic                       overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic [W-1:0]  mem_q [DEPTH];

   logic          stored;      // queue holds at least one record
   logic          deq_fire;    // head accepted by register read
   logic          pop_mem;     // dequeue comes out of storage
   logic          byp_a;       // slot A consumed by bypass
   logic          byp_b;       // slot B consumed by bypass
   logic          want_a;
   logic          want_b;
   logic          acc_a;
   logic          acc_b;
   logic [CW-1:0] space;
   logic [1:0]    n_wr;
   logic          wr0_en;
   logic          wr1_en;
   logic [W-1:0]  wr0_data;
   logic [PW-1:0] wr1_idx;

   // Head select, bypass, overflow trimming and next-state computation.
   always_comb begin
      // NOTE: every signal gets a default first so no path through this block infers a latch.
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      stored    = (count_q != '0);
      deq_valid = !flush && (stored || enq_a_valid || enq_b_valid);
      if (stored)           deq_data = mem_q[head_q];
      else if (enq_a_valid) deq_data = enq_a_data;
      else                  deq_data = enq_b_data;

      deq_fire = deq_valid && deq_ready;
      pop_mem  = deq_fire && stored;
      byp_a    = deq_fire && !stored && enq_a_valid;
      byp_b    = deq_fire && !stored && !enq_a_valid && enq_b_valid;

      want_a = enq_a_valid && !byp_a;
      want_b = enq_b_valid && !byp_b;

      // Room left after this cycle's dequeue; youngest record is dropped first.
      space = CW'(DEPTH) - count_q + CW'(pop_mem);
      acc_a = want_a && (space >= CW'(1));
      acc_b = want_b && (space >= (acc_a ? CW'(2) : CW'(1)));

      n_wr     = 2'(acc_a) + 2'(acc_b);
      wr0_en   = acc_a || acc_b;
      wr1_en   = acc_a && acc_b;
      wr0_data = acc_a ? enq_a_data : enq_b_data;
      wr1_idx  = tail_q + PW'(1);

      if (flush) begin
         head_d  = '0;
         tail_d  = refill_valid ? PW'(1) : '0;
         count_d = refill_valid ? CW'(1) : '0;
         wr0_en  = 1'b0;
         wr1_en  = 1'b0;
      end else begin
         head_d  = head_q + PW'(pop_mem);
         tail_d  = tail_q + PW'(n_wr);
         count_d = count_q + CW'(n_wr) - CW'(pop_mem);
         if ((want_a && !acc_a) || (want_b && !acc_b)) overflow_d = 1'b1;
      end
   end

   // Pointer, count and sticky error registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Record storage; writes at tail, tail+1, or entry 0 on a refill.
   // NOTE: storage is deliberately not reset; only the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (flush) begin
         if (refill_valid) mem_q[0] <= refill_data;
      end else begin
         if (wr0_en) mem_q[tail_q]  <= wr0_data;
         if (wr1_en) mem_q[wr1_idx] <= enq_b_data;
      end
   end

   assign free     = CW'(DEPTH) - count_q;
   assign empty    = (count_q == '0);
   assign overflow = overflow_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a reference queue of expected records is
// filled as stimulus is driven and drained as the DUT hands out its head.

module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int DEPTH = 8;
   localparam int W     = 64;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enq_a_valid, enq_b_valid, deq_ready, flush, refill_valid;
   logic [W-1:0]  enq_a_data, enq_b_data, refill_data;
   logic          deq_valid, empty, overflow;
   logic [W-1:0]  deq_data;
   logic [CW-1:0] free;

   int errors = 0;
   int checks = 0;

   logic [W-1:0] sb_q[$];   // expected records, oldest first
   logic         ovf_exp;

   fetch_queue #(.DEPTH(DEPTH), .W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .enq_a_valid(enq_a_valid), .enq_a_data(enq_a_data),
      .enq_b_valid(enq_b_valid), .enq_b_data(enq_b_data),
      .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_data(deq_data),
      .flush(flush), .refill_valid(refill_valid), .refill_data(refill_data),
      .free(free), .empty(empty), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, compare combinational and registered outputs
   // against the reference, advance the reference, then cross the edge.
   task automatic cycle(input logic a, input logic [W-1:0] da,
                        input logic b, input logic [W-1:0] db,
                        input logic rdy,
                        input logic fl = 1'b0, input logic rv = 1'b0,
                        input logic [W-1:0] rd = '0);
      logic         exp_valid;
      logic [W-1:0] exp_data;
      logic [W-1:0] inc[$];
      enq_a_valid = a;  enq_a_data = da;
      enq_b_valid = b;  enq_b_data = db;
      deq_ready = rdy;  flush = fl;
      refill_valid = rv; refill_data = rd;
      #1;
      inc = {};
      if (a) inc.push_back(da);
      if (b) inc.push_back(db);
      exp_valid = !fl && (sb_q.size() > 0 || a || b);
      exp_data  = (sb_q.size() > 0) ? sb_q[0] : (a ? da : db);
      check("free", W'(free), W'(DEPTH - sb_q.size()));
      check("empty", W'(empty), W'(sb_q.size() == 0));
      check("overflow", W'(overflow), W'(ovf_exp));
      check("deq_valid", W'(deq_valid), W'(exp_valid));
      if (exp_valid) check("deq_data", deq_data, exp_data);
      if (fl) begin
         sb_q = {};
         if (rv) sb_q.push_back(rd);
      end else begin
         if (exp_valid && rdy) begin
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            else void'(inc.pop_front());
         end
         foreach (inc[i]) begin
            if (sb_q.size() < DEPTH) sb_q.push_back(inc[i]);
            else ovf_exp = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      ovf_exp = 1'b0;
      enq_a_valid = 1'b0; enq_b_valid = 1'b0; deq_ready = 1'b0;
      flush = 1'b0; refill_valid = 1'b0;
      enq_a_data = '0; enq_b_data = '0; refill_data = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset state.
      cycle(0, 0, 0, 0, 0);

      // Bypass into an empty queue.
      cycle(1, 'h11, 0, 0, 1);
      cycle(0, 0, 0, 0, 1);

      // Move pointers off zero so the fill below wraps.
      cycle(1, 'h0A, 1, 'h0B, 0);
      cycle(1, 'h0C, 0, 0, 0);
      repeat (3) cycle(0, 0, 0, 0, 1);

      // Stall and fill with pairs 0x01..0x08, then drain across the wrap.
      for (int i = 0; i < 4; i++) cycle(1, W'(2*i+1), 1, W'(2*i+2), 0);
      cycle(0, 0, 0, 0, 0);
      check("free_full", W'(free), W'(0));
      repeat (9) cycle(0, 0, 0, 0, 1);

      // Overflow: count 7, then an A/B pair with no dequeue.
      for (int i = 0; i < 3; i++) cycle(1, W'('h31 + 2*i), 1, W'('h32 + 2*i), 0);
      cycle(1, 'h37, 0, 0, 0);
      cycle(1, 'h21, 1, 'h22, 0);
      cycle(0, 0, 0, 0, 0);
      check("overflow_set", W'(overflow), W'(1));

      // Drain to count 5, then flush with refill while enqueues are valid.
      repeat (3) cycle(0, 0, 0, 0, 1);
      cycle(1, 'h55, 1, 'h56, 1, 1, 1, 'h3C);
      cycle(0, 0, 0, 0, 0);
      check("refill_head", deq_data, W'('h3C));

      // Back to full, then B-only enqueue while dequeuing.
      for (int i = 0; i < 3; i++) cycle(1, W'('h61 + 2*i), 1, W'('h62 + 2*i), 0);
      cycle(1, 'h67, 0, 0, 0);
      cycle(0, 0, 1, 'h44, 1);
      cycle(0, 0, 0, 0, 0);
      check("free_after_b", W'(free), W'(0));
      cycle(1, 'h71, 1, 'h72, 1);   // full with dequeue: second write drops
      cycle(0, 0, 0, 0, 1);

      // Asynchronous reset mid-stream.
      #2 rst_n = 1'b0;
      sb_q = {};
      ovf_exp = 1'b0;
      #1;
      check("rst_empty", W'(empty), W'(1));
      check("rst_overflow", W'(overflow), W'(0));
      check("rst_free", W'(free), W'(DEPTH));
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      cycle(0, 0, 1, 'h99, 1);
      cycle(0, 0, 0, 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Two-wide-in, one-wide-out instruction queue between the decode pair (slots A and B) and the register-read stage. It accepts up to two decoded instruction records per cycle in program order and presents one per cycle to register read. It holds its head while register read stalls, bypasses straight through when empty, and on a pipeline flush either empties completely or restarts holding a single refill record.

## Interface
- `DEPTH`, 8: number of entries; must be a power of two, at least 4.
- `W`, 64: width of one decoded instruction record (the `R` record).
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enq_a_valid` in 1: decode slot A has a record this cycle.
- `enq_a_data` in W: slot A record; older than slot B.
- `enq_b_valid` in 1: decode slot B has a record; may be high with A low.
- `enq_b_data` in W: slot B record.
- `deq_ready` in 1: register read accepts the head this cycle; low means stall.
- `deq_valid` out 1: `deq_data` holds a valid record.
- `deq_data` out W: oldest record.
- `flush` in 1: discard all contents and all inputs this cycle.
- `refill_valid` in 1: sampled only with `flush`; the queue restarts holding `refill_data`.
- `refill_data` in W: record loaded on a flush with refill.
- `free` out $clog2(DEPTH)+1: DEPTH minus the registered count.
- `empty` out 1: registered count is 0.
- `overflow` out 1: sticky error; set when an enqueue is dropped.

## Operation
- State: `head` and `tail` pointers of $clog2(DEPTH) bits each, which wrap modulo DEPTH. `count` is $clog2(DEPTH)+1 bits. A storage array holds DEPTH×W bits. `overflow` is a flag.
- Head select:
  - When `count` > 0, the head is `mem[head]`.
  - When `count` = 0, the head is the bypass record: `enq_a_data` if `enq_a_valid`, else `enq_b_data` if `enq_b_valid`, else nothing.
- `deq_valid` = !`flush` && (count > 0 || `enq_a_valid` || `enq_b_valid`). `deq_data` carries the head record.
- A dequeue happens when `deq_valid` && `deq_ready`.
  - A bypassed record that is dequeued is never written to storage.
  - A bypassed record that is not dequeued because of a stall is written normally.
- Enqueue:
  - Valid slots are written at `tail`, then `tail+1`, in A-then-B order, skipping any slot consumed by bypass.
  - `tail` advances by the number of records written.
- Count update: count_next = count + written − (dequeue && count > 0 ? 1 : 0).
- Overflow:
  - If writing would make count_next exceed DEPTH, records are dropped youngest first (B before A) until it fits.
  - `overflow` is set and holds until reset.
  - Upstream is required to respect `free`, so overflow indicates a bug.
- Flush has priority over all other actions:
  - `head`, `tail` and `count` clear to 0.
  - Enqueue inputs are ignored and no dequeue occurs.
  - If `refill_valid` is also high, `mem[0]` receives `refill_data`, `tail` becomes 1 and `count` becomes 1.

## Timing
- Reset values: `head` = `tail` = `count` = 0, `overflow` = 0, so `empty` = 1, `free` = DEPTH, `deq_valid` = 0. Storage contents are undefined.
- Bypass latency: 0 cycles. A record enqueued into an empty queue is at `deq_data` in the same cycle.
- Stored latency: a record written at cycle n is visible as the head at cycle n+1 at the earliest.
- `free`, `empty` and `overflow` are registered-state derived and do not depend on same-cycle inputs.
- `deq_valid`/`deq_data` are combinational from the enq inputs and `flush`.
- `deq_ready` low at head: `head` holds; the head record stays stable next cycle unless a flush occurs.
- Full (count = DEPTH) with a dequeue: one write is accepted in the same cycle; a second write overflows.
- Pointer wrap: `head`/`tail` wrap from DEPTH−1 to 0 with no bubble.
- Reset asserted mid-operation: all state clears immediately and asynchronously; the queue is empty after `rst_n` rises.

## Structure
- Shared package holds:
  - the `R` record field layout, which sets W;
  - the `valid`, `PC` and `path` field macros;
  - the default `DEPTH`.
- No sub-modules; pointer/count logic and storage sit in one module.
- A `fetch_queue_ptr` helper is not warranted.

## Test plan
- Bypass: with the queue empty, raise `enq_a_valid` with record 0x11 and hold `deq_ready` = 1. Required: `deq_data` = 0x11 the same cycle; `count` stays 0; `empty` = 1 next cycle.
- Stall and fill: hold `deq_ready` = 0 and enqueue A/B pairs 0x01..0x08 over 4 cycles. Required: `free` = 0 and `deq_data` = 0x01 throughout. After releasing `deq_ready`, dequeue order is 0x01..0x08 with no gaps across the wrap.
- Overflow: with count = 7 and no dequeue, enqueue A = 0x21 and B = 0x22. Required: 0x21 is stored, 0x22 is dropped, `overflow` = 1 and stays set; count = 8.
- Flush with refill: with count = 5, assert `flush` with `refill_valid` and `refill_data` = 0x3C while enqueue inputs are valid. Required: next cycle count = 1, `deq_data` = 0x3C, and enqueue inputs are discarded.
- B-only and full dequeue: with count = 8, `deq_ready` = 1 and `enq_b_valid` only with 0x44, 0x44 is accepted and count stays 8. Then `rst_n` pulses low mid-stream: `empty` = 1 and `overflow` = 0 immediately.
